// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating mux.
//   rr_mode_e : arbitration mode encodings (FIXED_PRIO=0, ROUND_ROBIN=1)
//   chan_w()  : channel index width, clog2 with a minimum of 1 bit
package rr_arb_mux_pkg;

  typedef enum logic {
    FIXED_PRIO  = 1'b0,
    ROUND_ROBIN = 1'b1
  } rr_mode_e;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational grant logic for rr_arb_mux.
//   req   : per-channel request vector
//   ptr   : priority pointer, the channel searched first (ignored in fixed mode)
//   grant : one-hot grant, zero when no request is set
//   idx   : encoded index of the granted channel
//   any   : at least one request is set
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1,
  localparam int CHAN_W  = chan_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CHAN_W-1:0]   ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [CHAN_W-1:0]   idx,
  output logic                any
);

  logic        found;
  int unsigned cand;

  // Walk the channels starting at the pointer (or at 0 in fixed mode);
  // the modulo handles non-power-of-two channel counts.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cand = (RR_MODE == int'(ROUND_ROBIN)) ? (32'(ptr) + k) % CHANNELS : k;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = CHAN_W'(cand);
      end
    end
    any = found;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrating N:1 mux with a registered output slice.
//   CLK, RESET_N : clock (rising edge), asynchronous active-low reset
//   IN_DATA      : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   IN_VALID     : per-channel valid
//   IN_READY     : per-channel accept, one-hot or zero
//   OUT_DATA     : registered data of the granted channel
//   OUT_CHAN     : index of the channel held in OUT_DATA
//   OUT_VALID    : OUT_DATA/OUT_CHAN valid
//   OUT_READY    : downstream accept
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1,
  localparam int CHAN_W  = chan_w(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]       IN_VALID,
  output logic [CHANNELS-1:0]       IN_READY,
  output logic [WIDTH-1:0]          OUT_DATA,
  output logic [CHAN_W-1:0]         OUT_CHAN,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY
);

  logic [CHAN_W-1:0]   ptr;
  logic [CHANNELS-1:0] gnt;
  logic [CHAN_W-1:0]   gnt_idx;
  logic                any;
  logic                ld;
  logic [WIDTH-1:0]    sel_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .RR_MODE  (RR_MODE)
  ) u_arb (
    .req   (IN_VALID),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (any)
  );

  // RESET_N gates the load so no input is acknowledged while in reset.
  assign ld       = RESET_N && (!OUT_VALID || OUT_READY) && any;
  assign IN_READY = ld ? gnt : '0;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (gnt[i]) sel_data = IN_DATA[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_CHAN  <= '0;
    end else if (ld) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= sel_data;
      OUT_CHAN  <= gnt_idx;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr <= '0;
    end else if (ld && (RR_MODE == int'(ROUND_ROBIN))) begin
      ptr <= (gnt_idx == CHAN_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux. Three instances share stimulus:
//   dut 0: 4 channels, round-robin; dut 1: 4 channels, fixed priority;
//   dut 2: 3 channels, round-robin (uses the low 3 channels).
module tb_rr_arb_mux;

  logic        CLK;
  logic        RESET_N;
  logic        ordy;
  logic [3:0]  iv;
  logic [15:0] id;

  logic [3:0] rr_ready, fp_ready;
  logic [2:0] c3_ready;
  logic [3:0] rr_data, fp_data, c3_data;
  logic [1:0] rr_chan, fp_chan, c3_chan;
  logic       rr_valid, fp_valid, c3_valid;

  logic [3:0] a_ready [3];
  logic [3:0] a_data  [3];
  logic [1:0] a_chan  [3];
  logic       a_valid [3];

  int checks = 0;
  int errors = 0;

  localparam int NCH [3] = '{4, 4, 3};

  // Reference model state: the word held in the output stage and the
  // channel that gets first pick next time.
  logic       m_valid [3];
  logic [3:0] m_data  [3];
  int         m_chan  [3];
  int         m_ptr   [3];

  rr_arb_mux #(.WIDTH(4), .CHANNELS(4), .RR_MODE(1)) dut_rr (
    .CLK(CLK), .RESET_N(RESET_N), .IN_DATA(id), .IN_VALID(iv),
    .IN_READY(rr_ready), .OUT_DATA(rr_data), .OUT_CHAN(rr_chan),
    .OUT_VALID(rr_valid), .OUT_READY(ordy));

  rr_arb_mux #(.WIDTH(4), .CHANNELS(4), .RR_MODE(0)) dut_fp (
    .CLK(CLK), .RESET_N(RESET_N), .IN_DATA(id), .IN_VALID(iv),
    .IN_READY(fp_ready), .OUT_DATA(fp_data), .OUT_CHAN(fp_chan),
    .OUT_VALID(fp_valid), .OUT_READY(ordy));

  rr_arb_mux #(.WIDTH(4), .CHANNELS(3), .RR_MODE(1)) dut_c3 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_DATA(id[11:0]), .IN_VALID(iv[2:0]),
    .IN_READY(c3_ready), .OUT_DATA(c3_data), .OUT_CHAN(c3_chan),
    .OUT_VALID(c3_valid), .OUT_READY(ordy));

  assign a_ready[0] = rr_ready;
  assign a_ready[1] = fp_ready;
  assign a_ready[2] = {1'b0, c3_ready};
  assign a_data[0]  = rr_data;
  assign a_data[1]  = fp_data;
  assign a_data[2]  = c3_data;
  assign a_chan[0]  = rr_chan;
  assign a_chan[1]  = fp_chan;
  assign a_chan[2]  = c3_chan;
  assign a_valid[0] = rr_valid;
  assign a_valid[1] = fp_valid;
  assign a_valid[2] = c3_valid;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int winner(input int k);
    int start;
    start = (k == 1) ? 0 : m_ptr[k];
    for (int j = 0; j < NCH[k]; j++) begin
      if (iv[(start + j) % NCH[k]]) return (start + j) % NCH[k];
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int k);
    int w;
    w = winner(k);
    if (!RESET_N || w < 0 || (m_valid[k] && !ordy)) return 4'b0000;
    return 4'b0001 << w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = 4'd0;
      m_chan[k]  = 0;
      m_ptr[k]   = 0;
    end
  endtask

  // One clock: capture the model's decision from the inputs in front of
  // the edge, take the edge, update the model, settle 1 ns.
  task automatic cycle();
    int         w [3];
    logic [3:0] r [3];
    for (int k = 0; k < 3; k++) begin
      w[k] = winner(k);
      r[k] = exp_ready(k);
    end
    @(posedge CLK);
    for (int k = 0; k < 3; k++) begin
      if (r[k] != 4'b0000) begin
        m_valid[k] = 1'b1;
        m_data[k]  = id[w[k]*4 +: 4];
        m_chan[k]  = w[k];
        if (k != 1) m_ptr[k] = (w[k] + 1) % NCH[k];
      end else if (ordy) begin
        m_valid[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    iv      = 4'b0000;
    ordy    = 1'b0;
    RESET_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    iv      = 4'b1111;
    ordy    = 1'b1;
    id      = 16'h5378;
    RESET_N = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({a_valid[k], a_data[k], a_chan[k], a_ready[k]} !== 11'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got v=%b d=%h c=%0d r=%b, want all 0",
                 k, a_valid[k], a_data[k], a_chan[k], a_ready[k]);
      end
    end
    repeat (2) @(posedge CLK);
    #1;
    iv      = 4'b0000;
    RESET_N = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rr_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle_ready cyc%0d: got %b want 0000", i, rr_ready);
      end
      cycle();
      checks++;
      if (rr_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid cyc%0d: got %b want 0", i, rr_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_chan [5] = '{0, 1, 2, 3, 0};
    int exp_dat  [5] = '{8, 7, 3, 5, 8};
    iv   = 4'b1111;
    ordy = 1'b1;
    id   = {4'd5, 4'd3, 4'd7, 4'd8};
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rr_ready !== (4'b0001 << exp_chan[i]) || fp_ready !== 4'b0001) begin
        errors++;
        $display("FAIL b2b_ready cyc%0d: got rr=%b fp=%b want rr=%b fp=0001",
                 i, rr_ready, fp_ready, 4'b0001 << exp_chan[i]);
      end
      cycle();
      checks++;
      if (rr_valid !== 1'b1 || rr_chan !== 2'(exp_chan[i]) || rr_data !== 4'(exp_dat[i])) begin
        errors++;
        $display("FAIL b2b_rr cyc%0d: got v=%b c=%0d d=%0d want v=1 c=%0d d=%0d",
                 i, rr_valid, rr_chan, rr_data, exp_chan[i], exp_dat[i]);
      end
      checks++;
      if (fp_valid !== 1'b1 || fp_chan !== 2'd0 || fp_data !== 4'd8) begin
        errors++;
        $display("FAIL b2b_fixed cyc%0d: got v=%b c=%0d d=%0d want v=1 c=0 d=8",
                 i, fp_valid, fp_chan, fp_data);
      end
      checks++;
      if (c3_valid !== m_valid[2] || c3_chan !== 2'(m_chan[2]) || c3_data !== m_data[2]) begin
        errors++;
        $display("FAIL b2b_c3 cyc%0d: got c=%0d d=%0d want c=%0d d=%0d",
                 i, c3_chan, c3_data, m_chan[2], m_data[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    iv   = 4'b0100;
    ordy = 1'b1;
    cycle();
    checks++;
    if (rr_chan !== 2'd2 || rr_data !== 4'd3 || rr_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_load: got c=%0d d=%0d v=%b want c=2 d=3 v=1", rr_chan, rr_data, rr_valid);
    end
    ordy = 1'b0;
    iv   = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rr_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_ready cyc%0d: got %b want 0000", i, rr_ready);
      end
      cycle();
      checks++;
      if (rr_chan !== 2'd2 || rr_data !== 4'd3 || rr_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: got c=%0d d=%0d v=%b want c=2 d=3 v=1",
                 i, rr_chan, rr_data, rr_valid);
      end
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (rr_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1000", rr_ready);
    end
    cycle();
    checks++;
    if (rr_chan !== 2'd3 || rr_data !== 4'd5) begin
      errors++;
      $display("FAIL bp_release: got c=%0d d=%0d want c=3 d=5", rr_chan, rr_data);
    end
  endtask

  task automatic test_wrap_sparse();
    do_reset();
    id   = 16'h4321;
    ordy = 1'b1;
    iv   = 4'b0100;
    cycle();
    iv = 4'b0010;
    #1;
    checks++;
    if (rr_ready !== 4'b0010) begin
      errors++;
      $display("FAIL sparse_ready: got %b want 0010", rr_ready);
    end
    cycle();
    checks++;
    if (rr_chan !== 2'd1 || rr_data !== 4'd2) begin
      errors++;
      $display("FAIL sparse_grant: got c=%0d d=%0d want c=1 d=2", rr_chan, rr_data);
    end
    iv = 4'b0101;
    cycle();
    checks++;
    if (rr_chan !== 2'd2) begin
      errors++;
      $display("FAIL sparse_ptr: got c=%0d want 2", rr_chan);
    end

    do_reset();
    ordy = 1'b1;
    iv   = 4'b0100;
    cycle();
    checks++;
    if (c3_chan !== 2'd2 || c3_data !== 4'd3) begin
      errors++;
      $display("FAIL c3_first: got c=%0d d=%0d want c=2 d=3", c3_chan, c3_data);
    end
    iv = 4'b0011;
    #1;
    checks++;
    if (c3_ready !== 3'b001) begin
      errors++;
      $display("FAIL c3_wrap_ready: got %b want 001", c3_ready);
    end
    cycle();
    checks++;
    if (c3_chan !== 2'd0) begin
      errors++;
      $display("FAIL c3_wrap: got c=%0d want 0", c3_chan);
    end
    cycle();
    checks++;
    if (c3_chan !== 2'd1) begin
      errors++;
      $display("FAIL c3_ptr1: got c=%0d want 1", c3_chan);
    end
    iv = 4'b0101;
    cycle();
    checks++;
    if (c3_chan !== 2'd2) begin
      errors++;
      $display("FAIL c3_ptr2: got c=%0d want 2", c3_chan);
    end
  endtask

  task automatic test_drain();
    id   = 16'h9abc;
    ordy = 1'b1;
    iv   = 4'b1000;
    cycle();
    iv = 4'b0000;
    cycle();
    checks++;
    if (rr_valid !== 1'b0 || rr_chan !== 2'd3 || rr_data !== 4'h9) begin
      errors++;
      $display("FAIL drain: got v=%b c=%0d d=%h want v=0 c=3 d=9", rr_valid, rr_chan, rr_data);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    id   = 16'h1234;
    iv   = 4'b0100;
    ordy = 1'b0;
    cycle();
    checks++;
    if (rr_valid !== 1'b1 || rr_chan !== 2'd2) begin
      errors++;
      $display("FAIL areset_pre: got v=%b c=%0d want v=1 c=2", rr_valid, rr_chan);
    end
    RESET_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rr_valid !== 1'b0 || rr_data !== 4'd0 || rr_ready !== 4'b0000) begin
      errors++;
      $display("FAIL areset_drop: got v=%b d=%h r=%b want v=0 d=0 r=0000",
               rr_valid, rr_data, rr_ready);
    end
    #3;
    RESET_N = 1'b1;
    iv      = 4'b1010;
    ordy    = 1'b1;
    #1;
    checks++;
    if (rr_ready !== 4'b0010) begin
      errors++;
      $display("FAIL areset_ready: got %b want 0010", rr_ready);
    end
    cycle();
    checks++;
    if (rr_chan !== 2'd1 || rr_data !== 4'd3) begin
      errors++;
      $display("FAIL areset_grant: got c=%0d d=%0d want c=1 d=3", rr_chan, rr_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      iv   = 4'($urandom_range(0, 15));
      id   = 16'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (a_ready[k] !== exp_ready(k)) begin
          errors++;
          $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", k, i, a_ready[k], exp_ready(k));
        end
      end
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (a_valid[k] !== m_valid[k] || a_chan[k] !== 2'(m_chan[k]) || a_data[k] !== m_data[k]) begin
          errors++;
          $display("FAIL rand_out dut%0d cyc%0d: got v=%b c=%0d d=%h want v=%b c=%0d d=%h",
                   k, i, a_valid[k], a_chan[k], a_data[k], m_valid[k], m_chan[k], m_data[k]);
        end
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    iv      = 4'b0000;
    id      = 16'h0000;
    ordy    = 1'b0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap_sparse();
    test_drain();
    test_async_reset();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
